// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed driver for an N-digit common-anode
// 7-segment display. It scans shadowed hex nibbles one digit per refresh
// slot. Each slot opens with anode dead time to avoid ghosting. The module
// also provides per-digit decimal points and optional leading-zero blanking.
// New values are taken into the shadow registers only at frame boundaries,
// so a displayed number never tears.
module seven_seg_scan #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      load,
  input  logic                      blank_lz,
  input  logic                      en,
  output logic [6:0]                a_to_g,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_done
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
  localparam logic [DW-1:0] D_LAST  = DW'(NUM_DIGITS - 1);

  // Scan position
  logic [PW-1:0]             p_q, p_d;
  logic [DW-1:0]             d_q, d_d;

  // Capture (written by load) and shadow (displayed) registers
  logic [4*NUM_DIGITS-1:0]   cap_val_q, cap_val_d;
  logic [NUM_DIGITS-1:0]     cap_dp_q, cap_dp_d;
  logic                      pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0]   sh_val_q, sh_val_d;
  logic [NUM_DIGITS-1:0]     sh_dp_q, sh_dp_d;

  // Registered outputs
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic                      fd_q, fd_d;

  // Per-cycle digit information derived from the shadow registers
  logic [3:0]                cur_nib;
  logic                      cur_dp;
  logic                      cur_zero_run;
  logic                      cur_blanked;
  logic                      frame_start;

  // Hex nibble to active-low segment pattern, bit6=g ... bit0=a
  function automatic logic [6:0] decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Prescaler and digit index advance; both hold while disabled
  always_comb begin
    p_d = p_q;
    d_d = d_q;
    if (en) begin
      if (p_q == P_LAST) begin
        p_d = '0;
        d_d = (d_q == D_LAST) ? '0 : d_q + DW'(1);
      end else begin
        p_d = p_q + PW'(1);
      end
    end
  end

  // Capture on load; transfer capture to shadow on the first cycle of a frame.
  // A load in that same cycle lands in capture and keeps pending set.
  always_comb begin
    frame_start = en && (d_q == '0) && (p_q == '0);
    cap_val_d   = cap_val_q;
    cap_dp_d    = cap_dp_q;
    pend_d      = pend_q;
    sh_val_d    = sh_val_q;
    sh_dp_d     = sh_dp_q;
    if (frame_start && pend_q) begin
      sh_val_d = cap_val_q;
      sh_dp_d  = cap_dp_q;
      pend_d   = 1'b0;
    end
    if (load) begin
      cap_val_d = value;
      cap_dp_d  = dp_in;
      pend_d    = 1'b1;
    end
  end

  // Select the active digit. Walk from the top digit down so the zero run
  // at the selected digit tells whether everything at or above it is zero.
  always_comb begin
    cur_nib      = '0;
    cur_dp       = 1'b0;
    cur_zero_run = 1'b0;
    begin : lz_walk
      logic run;
      run = 1'b1;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        int unsigned i;
        i   = NUM_DIGITS - 1 - k;
        run = run && (sh_val_q[4*i +: 4] == 4'h0);
        if (DW'(i) == d_q) begin
          cur_nib      = sh_val_q[4*i +: 4];
          cur_dp       = sh_dp_q[i];
          cur_zero_run = run;
        end
      end
    end
    cur_blanked = blank_lz && (d_q != '0) && cur_zero_run;
  end

  // Next output values from the current scan position
  always_comb begin
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    an_d  = '1;
    fd_d  = en && (d_q == D_LAST) && (p_q == P_LAST);
    if (en && (p_q >= P_BLANK)) begin
      if (cur_blanked) begin
        // Blanked digit: segments off; anode lit only to show its decimal point
        dp_d = ~cur_dp;
        if (cur_dp) begin
          for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            an_d[i] = (DW'(i) != d_q);
          end
        end
      end else begin
        seg_d = decode(cur_nib);
        dp_d  = ~cur_dp;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          an_d[i] = (DW'(i) != d_q);
        end
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q       <= '0;
      d_q       <= '0;
      cap_val_q <= '0;
      cap_dp_q  <= '0;
      pend_q    <= 1'b0;
      sh_val_q  <= '0;
      sh_dp_q   <= '0;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      an_q      <= '1;
      fd_q      <= 1'b0;
    end else begin
      p_q       <= p_d;
      d_q       <= d_d;
      cap_val_q <= cap_val_d;
      cap_dp_q  <= cap_dp_d;
      pend_q    <= pend_d;
      sh_val_q  <= sh_val_d;
      sh_dp_q   <= sh_dp_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      fd_q      <= fd_d;
    end
  end

  assign a_to_g     = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
Time-multiplexed driver for an N-digit common-anode 7-segment display. It is the parametrised successor of the single-digit hex decoder. It scans NUM_DIGITS hex nibbles onto one shared active-low segment bus, one digit per refresh slot, and adds:
- a decimal point per digit
- leading-zero blanking
- anti-ghosting dead time
- tear-free value updates at frame boundaries

It sits between the board-level counters/datapath and the on-board display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 50000, clock cycles per digit slot (must exceed BLANK_CYCLES)
BLANK_CYCLES, 16, cycles at slot start with all anodes off (dead time, >=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
value  in  4*NUM_DIGITS  hex digits; nibble i drives digit i, digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point request per digit, active-high
load  in  1  strobe to capture value/dp_in for display
blank_lz  in  1  1 = suppress leading zeros
en  in  1  0 = display dark and scan held
a_to_g  out  7  segments, active-low, bit0=a ... bit6=g
dp  out  1  decimal point, active-low
an  out  NUM_DIGITS  digit anodes, active-low, one-hot-low when lit
frame_done  out  1  one-cycle pulse at the last cycle of each full scan

Behaviour:
- Reset (rst_n=0 at a rising edge) sets:
  - prescaler 0, digit index 0
  - capture and shadow registers 0, pending flag 0
  - a_to_g=7'h7F, dp=1, an=all ones, frame_done=0
  - Reset mid-scan aborts the slot immediately; the next cycle starts digit 0 slot, cycle 0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit index increments, wrapping NUM_DIGITS-1 to 0.
  - A frame is NUM_DIGITS*REFRESH_DIV cycles.
- All outputs are registered. Output values in cycle k reflect the state (digit d, prescaler p) of cycle k-1. Latency from reset release to the first lit anode is BLANK_CYCLES+1 cycles.
- Slot timing:
  - For p < BLANK_CYCLES: an = all ones, a_to_g=7'h7F, dp=1.
  - Otherwise: an[d]=0 with all other anodes 1; a_to_g = decode(shadow nibble d); dp = ~shadow_dp[d].
- Decode table (hex digit to a_to_g):
  - 0 -> 1000000, 1 -> 1111001, 2 -> 0100100, 3 -> 0110000
  - 4 -> 0011001, 5 -> 0010010, 6 -> 0000010, 7 -> 1111000
  - 8 -> 0000000, 9 -> 0010000, A -> 0001000, b -> 0000011
  - C -> 1000110, d -> 0100001, E -> 0000110, F -> 0001110
- Leading-zero blanking, when blank_lz=1:
  - Digit i (i>0) is blanked if shadow nibbles i..NUM_DIGITS-1 are all zero. Blanked means a_to_g=7'h7F and its anode stays high for the whole slot.
  - dp still shows on a blanked digit if shadow_dp[i]=1; in that case the anode is driven low and a_to_g=7'h7F.
  - Digit 0 is never blanked.
  - blank_lz is sampled live, not shadowed.
- Update path:
  - load=1 copies value/dp_in into the capture register and sets pending.
  - At the first cycle of the digit-0 slot (d=0, p=0), if pending=1: shadow <= capture and pending is cleared.
  - A load on that same cycle wins: capture gets the new data, pending stays 1, and it applies at the next frame.
  - Multiple loads within one frame: the last one wins.
- frame_done:
  - Registered pulse, high for exactly one cycle.
  - Asserted in the output cycle following state d=NUM_DIGITS-1, p=REFRESH_DIV-1.
- en=0:
  - Prescaler and digit index hold.
  - Outputs go dark on the next edge: an all ones, a_to_g=7'h7F, dp=1.
  - frame_done=0.
  - load is still accepted.
  - On en returning to 1, scanning resumes from the held position.
- value/dp_in changing without load has no visible effect.

Test Plan:
Setup for all cases: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
1. Reset then load value=16'h12AF, dp_in=4'b0000, en=1, blank_lz=0, then run 2 frames. Required response:
   - second frame slots show F,A,2,1 with an=1110,1101,1011,0111 for 3 cycles each, each preceded by 1 cycle of an=1111.
   - a_to_g for the four digits = 0001110, 0001000, 0100100, 1111001.
2. blank_lz=1, value=16'h0050, dp_in=4'b1000. Required response:
   - digits 0,1 lit (0 -> 1000000, 5 -> 0010010).
   - digit 2 an stays 1111.
   - digit 3 an=0111 with a_to_g=7F and dp=0.
   - With value=16'h0000, only digit 0 is lit, showing 0.
3. Load 16'h1111 mid-frame (digit 2 slot). Required response: digits 2 and 3 of the current frame keep the old value; the next frame shows 1s. Load asserted exactly on the d=0, p=0 cycle appears one frame later.
4. frame_done is high exactly one cycle every 16 cycles, aligned to the cycle after digit 3's last slot cycle; it is never high while en=0.
5. Drop en for 5 cycles during digit 1 slot, p=2. Required response: outputs are dark the next cycle; on resume, digit 1 continues from p=2, and frame length is extended by exactly 5 cycles.
6. Assert rst_n=0 for one cycle during digit 2. Required response: the next output cycle is a_to_g=7F, an=1111, dp=1; shadow is cleared, so the subsequent digit-0 slot shows 0 (1000000).
